ctrl_hazard_pipe: RTL and testbench
===================================

Name: ctrl_hazard_pipe

Overview:
- Consumer end of the ID-stage control decoder: accepts the decoded control bundle plus register addresses each cycle and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and generates the NoOp/Stall/PCWrite handshake back toward ID and IF.
- Produces EX-stage forwarding selects from the pipelined destination addresses.
- Sits beside the datapath pipeline registers in the 5-stage RISC-V core. It holds control and address fields only, no data.

Parameters:
- REG_ADDR_W, 5, register address width.
- ALUOP_W, 2, ALUOp field width (matches decoder: 00 add/ld/st/I, 10 R-type/beq).

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous active-high reset.
- Valid_i  in  1  ID instruction valid (0 = bubble/flushed slot).
- RS1addr_i  in  REG_ADDR_W  ID rs1.
- RS2addr_i  in  REG_ADDR_W  ID rs2.
- RDaddr_i  in  REG_ADDR_W  ID rd.
- ALUOp_i  in  ALUOP_W  decoded ALUOp.
- ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i  in  1 each  decoded controls.
- NoOp_o  out  1  bubble request to decoder/ID.
- Stall_o  out  1  hold IF/ID register.
- PCWrite_o  out  1  PC update enable.
- EX_ALUOp_o  out  ALUOP_W;  EX_ALUSrc_o, EX_Branch_o  out  1  EX-stage controls.
- EX_RS1addr_o, EX_RS2addr_o, EX_RDaddr_o  out  REG_ADDR_W.
- MEM_RegWrite_o, MEM_MemtoReg_o, MEM_MemRead_o, MEM_MemWrite_o  out  1;  MEM_RDaddr_o  out  REG_ADDR_W.
- WB_RegWrite_o, WB_MemtoReg_o  out  1;  WB_RDaddr_o  out  REG_ADDR_W.
- ForwardA_o, ForwardB_o  out  2  EX operand select: 00 regfile, 10 MEM result, 01 WB result.

Behaviour:
- Reset (rst_i=1 at posedge):
  - All ID/EX, EX/MEM and MEM/WB fields clear to 0, including EX_MemRead and EX_RegWrite.
  - Resulting outputs: NoOp_o=0, Stall_o=0, PCWrite_o=1, ForwardA_o=ForwardB_o=00.
  - Reset mid-operation discards every in-flight instruction on that edge. It has priority over all other inputs.
- Hazard (combinational, same cycle):
  - haz = Valid_i & EX_MemRead & (EX_RDaddr!=0) & ((EX_RDaddr==RS1addr_i) | (EX_RDaddr==RS2addr_i)).
  - Outputs: NoOp_o=haz, Stall_o=haz, PCWrite_o=~haz.
  - rs2 is compared even for I-type and load. This conservative false stall is accepted.
- ID/EX load at each posedge:
  - If haz or ~Valid_i: load the bubble. All control bits = 0 and ALUOp = 0. EX_RS1/RS2/RDaddr = 0.
  - Otherwise: capture the inputs.
  - The bubble has MemRead=0, so a stall lasts exactly one cycle. The ID instruction is re-presented by the held IF/ID on the next cycle.
- EX/MEM and MEM/WB always advance. No stall is applied beyond ID:
  - MEM_* <= EX_* (RegWrite, MemtoReg, MemRead, MemWrite, RDaddr).
  - WB_* <= MEM_*.
- Latency: ID inputs appear on EX_* after 1 clock, MEM_* after 2, WB_* after 3.
- Forwarding (combinational from registered state), shown for A (B identical with EX_RS2addr):
  - 10 if MEM_RegWrite & MEM_RDaddr!=0 & MEM_RDaddr==EX_RS1addr.
  - else 01 if WB_RegWrite & WB_RDaddr!=0 & WB_RDaddr==EX_RS1addr.
  - else 00.
  - MEM match wins over WB match.
- x0 never triggers a hazard or forwarding.
- Unknown or don't-care decoder outputs are passed through unchanged when Valid_i=1. The bench must drive defined values.

Test Plan:
- Reset: rst_i=1 for 2 cycles with random inputs -> all EX_/MEM_/WB_ outputs 0, PCWrite_o=1, Forward 00.
- Pipeline: add x3 issued (RegWrite=1, RD=3) -> EX_RDaddr_o=3 at +1, MEM_RDaddr_o=3 with MEM_RegWrite_o=1 at +2, WB_RDaddr_o=3 with WB_RegWrite_o=1 at +3.
- Load-use: lw x5, then next ID rs1=5 -> that cycle Stall_o=1, NoOp_o=1, PCWrite_o=0. Next cycle EX controls all 0 and Stall_o=0. Re-presented instruction then captured, with ForwardA_o=01 in its EX cycle.
- Double hazard: add x4, add x4, then rs1=4 in EX -> ForwardA_o=10 (MEM priority). Same sequence with rd=x0 -> 00, and lw x0 followed by rs1=0 -> no stall.
- Bubble: Valid_i=0 with MemRead_i=1, RD=7 -> no stall, EX_RDaddr_o=0, MEM_MemRead_o=0 one cycle later.
- Mid-run reset: assert rst_i while a load sits in MEM -> next edge WB_RegWrite_o=0, MEM outputs 0, no forward asserted.

Source files
------------

// File: rtl/ctrl_hazard_pipe.sv
// ctrl_hazard_pipe: control/address pipeline from ID through WB, load-use
// hazard detection and EX forwarding selects; holds no data.
// Ports: clk_i/rst_i (sync, active-high); ID-side decoded controls and
// register addresses in; NoOp_o/Stall_o/PCWrite_o back to ID/IF;
// EX_*, MEM_*, WB_* registered controls; ForwardA_o/ForwardB_o selects.
module ctrl_hazard_pipe #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  Valid_i,
    input  logic [REG_ADDR_W-1:0] RS1addr_i,
    input  logic [REG_ADDR_W-1:0] RS2addr_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_i,
    input  logic [ALUOP_W-1:0]    ALUOp_i,
    input  logic                  ALUSrc_i,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  Branch_i,
    output logic                  NoOp_o,
    output logic                  Stall_o,
    output logic                  PCWrite_o,
    output logic [ALUOP_W-1:0]    EX_ALUOp_o,
    output logic                  EX_ALUSrc_o,
    output logic                  EX_Branch_o,
    output logic [REG_ADDR_W-1:0] EX_RS1addr_o,
    output logic [REG_ADDR_W-1:0] EX_RS2addr_o,
    output logic [REG_ADDR_W-1:0] EX_RDaddr_o,
    output logic                  MEM_RegWrite_o,
    output logic                  MEM_MemtoReg_o,
    output logic                  MEM_MemRead_o,
    output logic                  MEM_MemWrite_o,
    output logic [REG_ADDR_W-1:0] MEM_RDaddr_o,
    output logic                  WB_RegWrite_o,
    output logic                  WB_MemtoReg_o,
    output logic [REG_ADDR_W-1:0] WB_RDaddr_o,
    output logic [1:0]            ForwardA_o,
    output logic [1:0]            ForwardB_o
);

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    logic exRegWrite;
    logic exMemtoReg;
    logic exMemRead;
    logic exMemWrite;
    logic hazard;
    logic loadBubble;

    // Load in EX whose rd feeds the ID instruction: hold IF/ID for one cycle.
    // rs2 is always compared, so I-type/loads may stall conservatively.
    assign hazard = Valid_i & exMemRead & (EX_RDaddr_o != X0)
                  & ((EX_RDaddr_o == RS1addr_i) | (EX_RDaddr_o == RS2addr_i));

    assign loadBubble = hazard | ~Valid_i;

    assign NoOp_o    = hazard;
    assign Stall_o   = hazard;
    assign PCWrite_o = ~hazard;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            EX_ALUOp_o   <= '0;
            EX_ALUSrc_o  <= 1'b0;
            EX_Branch_o  <= 1'b0;
            exRegWrite   <= 1'b0;
            exMemtoReg   <= 1'b0;
            exMemRead    <= 1'b0;
            exMemWrite   <= 1'b0;
            EX_RS1addr_o <= '0;
            EX_RS2addr_o <= '0;
            EX_RDaddr_o  <= '0;
        end else if (loadBubble) begin
            EX_ALUOp_o   <= '0;
            EX_ALUSrc_o  <= 1'b0;
            EX_Branch_o  <= 1'b0;
            exRegWrite   <= 1'b0;
            exMemtoReg   <= 1'b0;
            exMemRead    <= 1'b0;
            exMemWrite   <= 1'b0;
            EX_RS1addr_o <= '0;
            EX_RS2addr_o <= '0;
            EX_RDaddr_o  <= '0;
        end else begin
            EX_ALUOp_o   <= ALUOp_i;
            EX_ALUSrc_o  <= ALUSrc_i;
            EX_Branch_o  <= Branch_i;
            exRegWrite   <= RegWrite_i;
            exMemtoReg   <= MemtoReg_i;
            exMemRead    <= MemRead_i;
            exMemWrite   <= MemWrite_i;
            EX_RS1addr_o <= RS1addr_i;
            EX_RS2addr_o <= RS2addr_i;
            EX_RDaddr_o  <= RDaddr_i;
        end
    end

    // EX/MEM and MEM/WB never stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            MEM_RegWrite_o <= 1'b0;
            MEM_MemtoReg_o <= 1'b0;
            MEM_MemRead_o  <= 1'b0;
            MEM_MemWrite_o <= 1'b0;
            MEM_RDaddr_o   <= '0;
            WB_RegWrite_o  <= 1'b0;
            WB_MemtoReg_o  <= 1'b0;
            WB_RDaddr_o    <= '0;
        end else begin
            MEM_RegWrite_o <= exRegWrite;
            MEM_MemtoReg_o <= exMemtoReg;
            MEM_MemRead_o  <= exMemRead;
            MEM_MemWrite_o <= exMemWrite;
            MEM_RDaddr_o   <= EX_RDaddr_o;
            WB_RegWrite_o  <= MEM_RegWrite_o;
            WB_MemtoReg_o  <= MEM_MemtoReg_o;
            WB_RDaddr_o    <= MEM_RDaddr_o;
        end
    end

    // Youngest producer (MEM) wins over WB; x0 never forwards.
    function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (MEM_RegWrite_o && MEM_RDaddr_o != X0 && MEM_RDaddr_o == src)
            sel = 2'b10;
        else if (WB_RegWrite_o && WB_RDaddr_o != X0 && WB_RDaddr_o == src)
            sel = 2'b01;
        return sel;
    endfunction

    assign ForwardA_o = fwdSel(EX_RS1addr_o);
    assign ForwardB_o = fwdSel(EX_RS2addr_o);

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// tb_ctrl_hazard_pipe: directed vectors for ctrl_hazard_pipe with
// hand-computed expectations; prints one summary line.
module tb_ctrl_hazard_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] aluOp;
    logic       aluSrc, regWrite, memtoReg, memRead, memWrite, branch;
    logic       noOp, stall, pcWrite;
    logic [1:0] exAluOp;
    logic       exAluSrc, exBranch;
    logic [4:0] exRs1, exRs2, exRd;
    logic       memRegWrite, memMemtoReg, memMemRead, memMemWrite;
    logic [4:0] memRd;
    logic       wbRegWrite, wbMemtoReg;
    logic [4:0] wbRd;
    logic [1:0] fwdA, fwdB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_hazard_pipe dut (
        .clk_i(clk), .rst_i(rst), .Valid_i(valid),
        .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd),
        .ALUOp_i(aluOp), .ALUSrc_i(aluSrc), .RegWrite_i(regWrite),
        .MemtoReg_i(memtoReg), .MemRead_i(memRead),
        .MemWrite_i(memWrite), .Branch_i(branch),
        .NoOp_o(noOp), .Stall_o(stall), .PCWrite_o(pcWrite),
        .EX_ALUOp_o(exAluOp), .EX_ALUSrc_o(exAluSrc),
        .EX_Branch_o(exBranch), .EX_RS1addr_o(exRs1),
        .EX_RS2addr_o(exRs2), .EX_RDaddr_o(exRd),
        .MEM_RegWrite_o(memRegWrite), .MEM_MemtoReg_o(memMemtoReg),
        .MEM_MemRead_o(memMemRead), .MEM_MemWrite_o(memMemWrite),
        .MEM_RDaddr_o(memRd), .WB_RegWrite_o(wbRegWrite),
        .WB_MemtoReg_o(wbMemtoReg), .WB_RDaddr_o(wbRd),
        .ForwardA_o(fwdA), .ForwardB_o(fwdB)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int a, input int b,
                         input int d, input logic [1:0] op,
                         input logic src, input logic rw, input logic m2r,
                         input logic mr, input logic mw, input logic br);
        logic [31:0] ta, tb2, td;
        ta = a; tb2 = b; td = d;
        valid = v; rs1 = ta[4:0]; rs2 = tb2[4:0]; rd = td[4:0];
        aluOp = op; aluSrc = src; regWrite = rw; memtoReg = m2r;
        memRead = mr; memWrite = mw; branch = br;
    endtask

    task automatic bubble();
        drive(1'b0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        r = $urandom;
        drive(r[0], r[5:1], r[10:6], r[15:11], r[17:16], r[18], r[19],
              r[20], r[21], r[22], r[23]);
        step();
        r = $urandom;
        drive(r[0], r[5:1], r[10:6], r[15:11], r[17:16], r[18], r[19],
              r[20], r[21], r[22], r[23]);
        step();
        check("rst_exRd", exRd, 0);
        check("rst_exAluOp", exAluOp, 0);
        check("rst_memRegWrite", memRegWrite, 0);
        check("rst_memMemRead", memMemRead, 0);
        check("rst_wbRegWrite", wbRegWrite, 0);
        check("rst_wbRd", wbRd, 0);
        check("rst_pcWrite", pcWrite, 1);
        check("rst_stall", stall, 0);
        check("rst_fwdA", fwdA, 0);
        check("rst_fwdB", fwdB, 0);

        // add x3, x1, x2 through the pipe
        rst = 1'b0;
        drive(1, 1, 2, 3, 2'b10, 0, 1, 0, 0, 0, 0);
        step();
        check("add_exRd", exRd, 3);
        check("add_exAluOp", exAluOp, 2);
        bubble();
        step();
        check("add_memRd", memRd, 3);
        check("add_memRegWrite", memRegWrite, 1);
        check("bub_exRd", exRd, 0);
        step();
        check("add_wbRd", wbRd, 3);
        check("add_wbRegWrite", wbRegWrite, 1);
        step();

        // lw x5 then add x7, x5, x6
        drive(1, 1, 0, 5, 2'b00, 1, 1, 1, 1, 0, 0);
        step();
        drive(1, 5, 6, 7, 2'b10, 0, 1, 0, 0, 0, 0);
        #1;
        check("lu_stall", stall, 1);
        check("lu_noop", noOp, 1);
        check("lu_pcWrite", pcWrite, 0);
        step();
        check("lu_bub_exAluOp", exAluOp, 0);
        check("lu_bub_exAluSrc", exAluSrc, 0);
        check("lu_bub_exRd", exRd, 0);
        check("lu_bub_stall", stall, 0);
        check("lu_memMemRead", memMemRead, 1);
        step();
        check("lu_cap_exRd", exRd, 7);
        check("lu_cap_exRs1", exRs1, 5);
        check("lu_fwdA", fwdA, 2'b01);
        check("lu_fwdB", fwdB, 2'b00);
        check("lu_wbMemtoReg", wbMemtoReg, 1);

        // add x4 twice, then consumer of x4 on both operands
        drive(1, 1, 2, 4, 2'b10, 0, 1, 0, 0, 0, 0);
        step();
        step();
        drive(1, 4, 4, 8, 2'b10, 0, 1, 0, 0, 0, 0);
        step();
        check("dbl_fwdA", fwdA, 2'b10);
        check("dbl_fwdB", fwdB, 2'b10);

        // same with rd=x0
        drive(1, 1, 2, 0, 2'b10, 0, 1, 0, 0, 0, 0);
        step();
        step();
        drive(1, 0, 0, 8, 2'b10, 0, 1, 0, 0, 0, 0);
        step();
        check("x0_fwdA", fwdA, 2'b00);
        check("x0_fwdB", fwdB, 2'b00);

        // lw x0 then rs1=x0: no stall
        drive(1, 1, 2, 0, 2'b00, 1, 1, 1, 1, 0, 0);
        step();
        drive(1, 0, 3, 9, 2'b10, 0, 1, 0, 0, 0, 0);
        #1;
        check("lwx0_stall", stall, 0);
        check("lwx0_pcWrite", pcWrite, 1);

        // invalid slot with loud controls becomes a bubble
        drive(0, 5, 5, 7, 2'b10, 1, 1, 1, 1, 1, 1);
        step();
        drive(0, 7, 7, 7, 2'b10, 1, 1, 1, 1, 1, 1);
        #1;
        check("inv_stall", stall, 0);
        check("inv_exRd", exRd, 0);
        check("inv_exBranch", exBranch, 0);
        step();
        check("inv_memMemRead", memMemRead, 0);
        check("inv_memMemWrite", memMemWrite, 0);

        // mid-run reset with a load in MEM
        drive(1, 1, 2, 9, 2'b00, 1, 1, 1, 1, 0, 0);
        step();
        drive(1, 1, 2, 10, 2'b10, 0, 1, 0, 0, 0, 0);
        step();
        check("mr_memMemRead_pre", memMemRead, 1);
        check("mr_memRd_pre", memRd, 9);
        rst = 1'b1;
        drive(1, 9, 10, 11, 2'b10, 0, 1, 0, 0, 0, 0);
        step();
        check("mr_wbRegWrite", wbRegWrite, 0);
        check("mr_memRegWrite", memRegWrite, 0);
        check("mr_memMemRead", memMemRead, 0);
        check("mr_memRd", memRd, 0);
        check("mr_exRd", exRd, 0);
        check("mr_fwdA", fwdA, 2'b00);
        check("mr_fwdB", fwdB, 2'b00);
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
